// File: rtl/ctrl_pkg.sv
// Shared types and defaults for the SMAC output-bank controllers.
// Holds the read-side FSM encoding and the default bank geometry.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } ctrl_re_state_t;

    localparam int NGRP_DEF = 8;
    localparam int WPG_DEF  = 8;

    // Index width that stays legal when a group holds a single word
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_onehot_rot.sv
// One-hot rotate-left group select, shared by the bank fill and drain sides.
// Resets and clears to bit 0; each advance moves the hot bit up one, wrapping the top bit to bit 0.
module ctrl_onehot_rot #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         adv_i,
    output logic [N-1:0] sel_o
);

    localparam logic [N-1:0] SEL_INIT = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] sel_q;
    logic [N-1:0] sel_d;

    // Next select: clear wins over advance, otherwise hold
    always_comb begin
        sel_d = sel_q;
        if (clr_i) begin
            sel_d = SEL_INIT;
        end else if (adv_i) begin
            sel_d = {sel_q[N-2:0], sel_q[N-1]};
        end else begin
            sel_d = sel_q;
        end
    end

    // Select register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= SEL_INIT;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel_o = sel_q;

endmodule

// File: rtl/ctrl_sr_re.sv
// Read-side controller for the SMAC output register bank: walks group/word in fill order
// and presents each fetched word through a registered valid/ready output stage.
module ctrl_sr_re
    import ctrl_pkg::*;
#(
    parameter int  NGRP  = NGRP_DEF,
    parameter int  WPG   = WPG_DEF,
    parameter int  W     = 16,
    localparam int IDX_W = idx_width(WPG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cnt_clear,
    input  logic [W-1:0]     rd_data_in,
    input  logic             out_ready,
    output logic [NGRP-1:0]  rd_grp_sel,
    output logic [IDX_W-1:0] rd_word_idx,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WPG - 1);

    ctrl_re_state_t   state_q, state_d;
    logic [IDX_W-1:0] word_q, word_d;
    logic [W-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;

    logic [NGRP-1:0]  grp_sel_s;
    logic             load_s;
    logic             word_end_s;
    logic             bank_end_s;
    logic             grp_adv_s;

    // The output stage refills whenever it is empty or its word is leaving this cycle
    assign load_s     = (state_q == DRAIN) && (!valid_q || out_ready) && !cnt_clear;
    assign word_end_s = (word_q == WORD_LAST);
    assign bank_end_s = grp_sel_s[NGRP-1] && word_end_s;
    assign grp_adv_s  = load_s && word_end_s;

    ctrl_onehot_rot #(
        .N (NGRP)
    ) u_grp_rot (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clear),
        .adv_i (grp_adv_s),
        .sel_o (grp_sel_s)
    );

    // FSM, word pointer and output stage next-state
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        if (cnt_clear) begin
            state_d = IDLE;
            word_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (load_s) begin
                        data_d  = rd_data_in;
                        valid_d = 1'b1;
                        last_d  = bank_end_s;
                        if (word_end_s) begin
                            word_d = '0;
                        end else begin
                            word_d = word_q + IDX_W'(1);
                        end
                        if (bank_end_s) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        state_d = DRAIN;
                    end
                end
                FLUSH: begin
                    // Final word is still held in the stage; retire it before reporting done
                    if (out_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                    end
                end
                default: begin
                    state_d = IDLE;
                    word_d  = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign rd_grp_sel  = grp_sel_s;
    assign rd_word_idx = word_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule
